// File: rtl/mem_pkg.sv
// Shared memory-bus definitions: command encodings, arbiter state enum, request qualifier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_ADDR = 2'd2,
        RD_DATA = 2'd3
    } arb_state_e;

    // Only MREAD and MWRITE are real requests; MNONE and the spare code 11 are ignored.
    function automatic logic req_valid(input logic req, input logic [1:0] cmd);
        return req && ((cmd == MREAD) || (cmd == MWRITE));
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Two-way winner selection: sole requester wins, ties alternate, CPU wins ties after a quiet cycle.
// Latency: combinational.
// Backpressure: none; evaluated only while the arbiter is idle.
// Ports: vld_0/vld_1 qualified requests, last_gnt index of last winner,
//        idle set when an arbitration cycle passed with no request, winner chosen index.
module rr_pick #(
    parameter bit CPU_PRIO = 1'b1
) (
    input  logic vld_0,
    input  logic vld_1,
    input  logic last_gnt,
    input  logic idle,
    output logic winner
);

    always_comb begin
        winner = 1'b0;
        if (vld_1 && !vld_0) begin
            winner = 1'b1;
        end else if (vld_0 && vld_1) begin
            winner = (CPU_PRIO && idle) ? 1'b0 : ~last_gnt;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port RAM arbiter (0 = CPU, 1 = DMA/debug), one access at a time.
// Latency: write issues in the cycle after the request is seen; read data returns two cycles after.
// Backpressure: a requester holds req_n until gnt_n; an IDLE cycle separates every access.
// Ports: req_n/cmd_n/addr_n/wdata_n request side, gnt_n/rvalid_n/rdata responses,
//        mem_cmd/mem_addr/mem_wdata/mem_rdata RAM side (mem_rdata registered by the RAM).
module mem_arbiter
    import mem_pkg::*;
#(
    parameter bit CPU_PRIO = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_0,
    input  logic [1:0]        cmd_0,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [DATA_W-1:0] wdata_0,
    output logic              gnt_0,
    output logic              rvalid_0,
    input  logic              req_1,
    input  logic [1:0]        cmd_1,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [DATA_W-1:0] wdata_1,
    output logic              gnt_1,
    output logic              rvalid_1,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        state, state_nxt;
    logic              vld_0, vld_1, any_vld, pick;
    logic [1:0]        pick_cmd;
    logic              win_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              last_gnt_q;
    logic              idle_q;

    assign vld_0    = req_valid(req_0, cmd_0);
    assign vld_1    = req_valid(req_1, cmd_1);
    assign any_vld  = vld_0 | vld_1;
    assign pick_cmd = pick ? cmd_1 : cmd_0;

    rr_pick #(.CPU_PRIO(CPU_PRIO)) u_rr_pick (
        .vld_0    (vld_0),
        .vld_1    (vld_1),
        .last_gnt (last_gnt_q),
        .idle     (idle_q),
        .winner   (pick)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; every access returns to IDLE so held requests are re-arbitrated there.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_vld) state_nxt = (pick_cmd == MWRITE) ? WR : RD_ADDR;
            WR:      state_nxt = IDLE;
            RD_ADDR: state_nxt = RD_DATA;
            RD_DATA: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Winner capture. The request fields are frozen here so requester activity during
    // the access cannot reach the RAM. idle_q remembers that an arbitration cycle went
    // unused, which hands ties back to the CPU; the mandatory post-access IDLE does not count.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            last_gnt_q <= 1'b1;
            idle_q     <= 1'b1;
        end else if (state == IDLE) begin
            if (any_vld) begin
                win_q      <= pick;
                addr_q     <= pick ? addr_1 : addr_0;
                wdata_q    <= pick ? wdata_1 : wdata_0;
                last_gnt_q <= pick;
                idle_q     <= 1'b0;
            end else begin
                idle_q     <= 1'b1;
            end
        end
    end

    // Outputs decoded from state and captured winner; everything is zero outside a grant.
    always_comb begin
        gnt_0     = 1'b0;
        gnt_1     = 1'b0;
        rvalid_0  = 1'b0;
        rvalid_1  = 1'b0;
        rdata     = '0;
        mem_cmd   = MNONE;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            WR: begin
                gnt_0     = ~win_q;
                gnt_1     = win_q;
                mem_cmd   = MWRITE;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            RD_ADDR: begin
                gnt_0    = ~win_q;
                gnt_1    = win_q;
                mem_cmd  = MREAD;
                mem_addr = addr_q;
            end
            RD_DATA: begin
                gnt_0    = ~win_q;
                gnt_1    = win_q;
                mem_cmd  = MREAD;
                mem_addr = addr_q;
                rdata    = mem_rdata;
                rvalid_0 = ~win_q;
                rvalid_1 = win_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then randomized traffic,
// compared every cycle against a transaction-level schedule model.
// Counting: the request cycle is cycle 1, MWRITE lands in cycle 2, rvalid in cycle 3.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_0, req_1;
    logic [1:0]  cmd_0, cmd_1;
    logic [8:0]  addr_0, addr_1;
    logic [15:0] wdata_0, wdata_1;
    logic        gnt_0, gnt_1, rvalid_0, rvalid_1;
    logic [15:0] rdata;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_0     (req_0),
        .cmd_0     (cmd_0),
        .addr_0    (addr_0),
        .wdata_0   (wdata_0),
        .gnt_0     (gnt_0),
        .rvalid_0  (rvalid_0),
        .req_1     (req_1),
        .cmd_1     (cmd_1),
        .addr_1    (addr_1),
        .wdata_1   (wdata_1),
        .gnt_1     (gnt_1),
        .rvalid_1  (rvalid_1),
        .rdata     (rdata),
        .mem_cmd   (mem_cmd),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Expected bus picture for one cycle
    typedef struct packed {
        logic        g0;
        logic        g1;
        logic [1:0]  cmd;
        logic [8:0]  addr;
        logic [15:0] wdata;
        logic        v0;
        logic        v1;
        logic [15:0] rdata;
    } exp_t;

    exp_t        sched[$];     // expected outputs for upcoming cycles of the current access
    logic [15:0] ram [512];    // the RAM attached to the DUT
    logic [15:0] model_mem [512];
    logic        m_last;       // requester granted last
    logic        m_quiet;      // an arbitration opportunity went unused since that grant
    logic        armed;
    int          n_chk, n_err, cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d got %h exp %h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_step();
        exp_t        e;
        exp_t        r;
        bit          free;
        logic        ok0, ok1, w;
        logic [1:0]  c;
        logic [8:0]  a;
        logic [15:0] d;
        free = (sched.size() == 0);
        e    = free ? exp_t'(0) : sched.pop_front();
        if (armed) begin
            chk("gnt",    {30'd0, gnt_1, gnt_0},       {30'd0, e.g1, e.g0});
            chk("rvalid", {30'd0, rvalid_1, rvalid_0}, {30'd0, e.v1, e.v0});
            chk("mem_cmd",   {30'd0, mem_cmd},  {30'd0, e.cmd});
            chk("mem_addr",  {23'd0, mem_addr}, {23'd0, e.addr});
            chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, e.wdata});
            chk("rdata",     {16'd0, rdata},    {16'd0, e.rdata});
        end
        if (reset) begin
            sched.delete();
            m_last  = 1'b1;
            m_quiet = 1'b1;
            armed   = 1'b1;
            return;
        end
        if (!free) return;
        ok0 = req_0 && (cmd_0 == 2'b01 || cmd_0 == 2'b10);
        ok1 = req_1 && (cmd_1 == 2'b01 || cmd_1 == 2'b10);
        if (!ok0 && !ok1) begin
            m_quiet = 1'b1;
            return;
        end
        if (ok0 && ok1) w = m_quiet ? 1'b0 : ~m_last;
        else            w = ok1;
        c = w ? cmd_1 : cmd_0;
        a = w ? addr_1 : addr_0;
        d = w ? wdata_1 : wdata_0;
        m_last  = w;
        m_quiet = 1'b0;
        r      = '0;
        r.g0   = ~w;
        r.g1   = w;
        r.addr = a;
        if (c == 2'b10) begin
            r.cmd   = 2'b10;
            r.wdata = d;
            sched.push_back(r);
            model_mem[a] = d;
        end else begin
            r.cmd = 2'b01;
            sched.push_back(r);
            r.v0    = ~w;
            r.v1    = w;
            r.rdata = model_mem[a];
            sched.push_back(r);
        end
    endtask

    // One clock cycle with the inputs already applied: check at negedge, act as the RAM,
    // then advance to just after the next rising edge.
    task automatic step();
        logic [15:0] rd_nxt;
        @(negedge clk);
        model_step();
        rd_nxt = mem_rdata;
        if (mem_cmd == 2'b01) rd_nxt = ram[mem_addr];
        if (mem_cmd == 2'b10) ram[mem_addr] = mem_wdata;
        @(posedge clk);
        mem_rdata = rd_nxt;
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        req_0 = 1'b0; cmd_0 = 2'b00; addr_0 = '0; wdata_0 = '0;
        req_1 = 1'b0; cmd_1 = 2'b00; addr_1 = '0; wdata_1 = '0;
    endtask

    initial begin
        n_chk = 0; n_err = 0; cyc = 0;
        armed = 1'b0; m_last = 1'b1; m_quiet = 1'b1;
        mem_rdata = '0;
        for (int i = 0; i < 512; i++) begin
            ram[i]       = 16'(i * 37) ^ 16'h5A5A;
            model_mem[i] = 16'(i * 37) ^ 16'h5A5A;
        end
        ram[5]       = 16'hABCD;
        model_mem[5] = 16'hABCD;
        idle_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        step(); step();
        reset = 1'b0;
        step();

        // Single CPU read of 0x005
        req_0 = 1'b1; cmd_0 = 2'b01; addr_0 = 9'h005;
        step();
        idle_inputs();
        repeat (4) step();

        // Both write at once and hold: 0, IDLE, 1, IDLE, 0
        req_0 = 1'b1; cmd_0 = 2'b10; addr_0 = 9'h010; wdata_0 = 16'h1111;
        req_1 = 1'b1; cmd_1 = 2'b10; addr_1 = 9'h020; wdata_1 = 16'h2222;
        repeat (5) step();
        idle_inputs();
        repeat (3) step();
        chk("ram_010", {16'd0, ram[9'h010]}, 32'h1111);
        chk("ram_020", {16'd0, ram[9'h020]}, 32'h2222);

        // DMA read; request dropped and address changed during RD_ADDR
        req_1 = 1'b1; cmd_1 = 2'b01; addr_1 = 9'h020;
        step();
        req_1 = 1'b0; addr_1 = 9'h1FF;
        repeat (4) step();
        idle_inputs();

        // Reset during RD_ADDR abandons the read; requester 0 wins next
        req_1 = 1'b1; cmd_1 = 2'b01; addr_1 = 9'h030;
        step();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_0 = 1'b1; cmd_0 = 2'b01; addr_0 = 9'h040;
        req_1 = 1'b1; cmd_1 = 2'b01; addr_1 = 9'h050;
        step();
        idle_inputs();
        repeat (4) step();

        // Reserved command code is ignored
        req_0 = 1'b1; cmd_0 = 2'b11; addr_0 = 9'h077; wdata_0 = 16'hDEAD;
        repeat (6) step();
        idle_inputs();
        step();

        // Randomized traffic with occasional resets
        repeat (3000) begin
            req_0   = ($urandom_range(0, 3) != 0);
            cmd_0   = 2'($urandom_range(0, 3));
            addr_0  = 9'($urandom_range(0, 63));
            wdata_0 = 16'($urandom);
            req_1   = ($urandom_range(0, 2) != 0);
            cmd_1   = 2'($urandom_range(0, 3));
            addr_1  = 9'($urandom_range(0, 63));
            wdata_1 = 16'($urandom);
            reset   = ($urandom_range(0, 59) == 0);
            step();
        end
        reset = 1'b0;
        idle_inputs();
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-002 Ports SHALL be, per requester n in {0,1} (0 = CPU fetch/LDR/STR, 1 = DMA/debug):
  req_n  in  1  access request
  cmd_n  in  2  MNONE=00, MREAD=01, MWRITE=10
  addr_n  in  9  word address
  wdata_n  in  16  write data
  gnt_n  out  1  grant, high for whole access
  rvalid_n  out  1  read data valid, one-cycle pulse
  rdata  out  16  read data, shared, meaningful only with rvalid_n
REQ-003 Memory-side ports SHALL be:
  mem_cmd  out  2  command to RAM
  mem_addr  out  9  RAM address
  mem_wdata  out  16  RAM write data
  mem_rdata  in  16  RAM data, registered, valid one cycle after MREAD address
REQ-004 The parameter SHALL be CPU_PRIO, default 1, meaning requester 0 wins ties after reset and after any idle cycle.

Function
REQ-005 A request SHALL be valid when req_n=1 and cmd_n is MREAD or MWRITE; cmd_n=MNONE or 11 SHALL be ignored.
REQ-006 States SHALL be IDLE, WR, RD_ADDR, RD_DATA.
REQ-007 IDLE: with no valid request, mem_cmd=MNONE and all gnt_n=0; with a valid request, the winner SHALL be registered and the state SHALL go to WR or RD_ADDR on the next edge.
REQ-008 Arbitration: if only one request is valid, it SHALL win. If both are valid, the requester not granted last SHALL win (round-robin). When CPU_PRIO=1 and the last grant was followed by an idle cycle, requester 0 SHALL win.
REQ-009 WR (one cycle): gnt=1, mem_cmd=MWRITE, mem_addr/mem_wdata from the winner; next state IDLE.
REQ-010 RD_ADDR: gnt=1, mem_cmd=MREAD, mem_addr from the winner; next state RD_DATA.
REQ-011 RD_DATA: gnt=1, mem_cmd=MREAD, same mem_addr, rdata=mem_rdata, rvalid_n=1 for the winner; next state IDLE.
REQ-012 Read latency SHALL be 3 cycles from the request edge to rvalid; write latency SHALL be 2 cycles from request to the MWRITE cycle.
REQ-013 The winner's cmd_n, addr_n and wdata_n SHALL be captured at grant; requester changes during an access SHALL NOT affect the memory outputs.
REQ-014 A request held high through completion SHALL be re-arbitrated in the IDLE cycle that follows. There SHALL be no back-to-back accesses without an IDLE cycle.
REQ-015 A req_n deassertion mid-access SHALL NOT abort the access.
REQ-016 Outside a grant, mem_addr and mem_wdata SHALL be 0 and rdata SHALL be 0.

Reset
REQ-017 When reset=1 at an edge, the state SHALL become IDLE, gnt_n=0, rvalid_n=0, mem_cmd=MNONE, mem_addr=0, mem_wdata=0, and last-grant=1 (so requester 0 wins first).
REQ-018 A reset during RD_ADDR, RD_DATA or WR SHALL abandon the access with no rvalid pulse; mem_cmd SHALL be MNONE from the next cycle.

Structure
REQ-019 The mem_cmd encodings (MNONE/MREAD/MWRITE) and the state enum SHALL live in a shared package, mem_pkg, which the CPU FSM also imports.
REQ-020 The winner selection SHALL be one combinational sub-module, rr_pick (inputs: two valid bits, last grant, idle flag, CPU_PRIO; output: winner index). Everything else SHALL be in mem_arbiter.

Verification
REQ-021 Reset, then req_0 MREAD addr 0x005 with mem_rdata=0xABCD: gnt_0 high for 2 cycles, mem_cmd=01 for 2 cycles, rvalid_0 pulse with rdata=0xABCD 3 cycles after the request.
REQ-022 Both requesters assert at once: req_0 MWRITE 0x010/0x1111 and req_1 MWRITE 0x020/0x2222, both held: order is 0, IDLE, 1, IDLE, 0; RAM sees 0x010<=0x1111 then 0x020<=0x2222.
REQ-023 req_1 MREAD granted, then req_1 drops and addr_1 changes in RD_ADDR: the access still completes at the original address and rvalid_1 pulses.
REQ-024 Reset asserted in RD_ADDR: no rvalid, mem_cmd=00 in the following cycle, state IDLE; the next grant goes to requester 0.
REQ-025 cmd_0=11 with req_0=1 and nothing else: no grant, mem_cmd stays 00 indefinitely.
